// File: rtl/shiftreg_pkg.sv
// Types and constants shared by the shift-register link transmitter and receiver.
package shiftreg_pkg;

    localparam int SHIFTREG_WIDTH = 4;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_SHIFT  = 2'd1,
        RX_PARITY = 2'd2
    } rx_state_e;

endpackage

// File: rtl/shiftreg_rx_if.sv
// Serial line plus word handshake between the shift-register receiver and its
// line driver / consumer.
interface shiftreg_rx_if
    import shiftreg_pkg::*;
#(
    parameter int WIDTH = SHIFTREG_WIDTH
) ();

    logic             enable;
    logic             sync;
    logic             serial_in;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             overrun;
    logic             parity_err;

    modport master (
        output enable, sync, serial_in, data_ready,
        input  data_out, data_valid, overrun, parity_err
    );

    modport slave (
        input  enable, sync, serial_in, data_ready,
        output data_out, data_valid, overrun, parity_err
    );

endinterface

// File: rtl/shiftreg_rx_shifter.sv
// MSB-first shift register with a saturating bit counter; word_o presents the
// word as it will look once the bit currently on bit_in is taken (or the held word when full).
module shiftreg_rx_shifter
    import shiftreg_pkg::*;
#(
    parameter int WIDTH = SHIFTREG_WIDTH,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word_o,
    output logic             last_o,
    output logic             full_o
);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load) begin
            shreg_d = {{(WIDTH-1){1'b0}}, bit_in};
            cnt_d   = CW'(1);
        end else if (shift) begin
            shreg_d = {shreg_q[WIDTH-2:0], bit_in};
            cnt_d   = cnt_q + CW'(1);
        end
    end

    assign last_o = (cnt_q == CW'(WIDTH - 1));
    assign full_o = (cnt_q == CW'(WIDTH));
    assign word_o = full_o ? shreg_q : {shreg_q[WIDTH-2:0], bit_in};

    // Data register carries no reset; only the counter is control state.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shiftreg_rx.sv
// Serial-in parallel-out receiver: frame FSM, word delivery with valid/ready
// handshake and sticky overrun. Optional even parity bit via SHIFTREG_RX_PARITY_EN.
module shiftreg_rx
    import shiftreg_pkg::*;
#(
    parameter int WIDTH = SHIFTREG_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    shiftreg_rx_if.slave  bus
);

    rx_state_e        state_q, state_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             overrun_q, overrun_d;
    logic             parity_err_q, parity_err_d;

    logic             sh_load, sh_shift, sh_last, sh_full;
    logic             deliver, word_perr;
    logic [WIDTH-1:0] sh_word;

    shiftreg_rx_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk    (clk),
        .reset  (reset),
        .load   (sh_load),
        .shift  (sh_shift),
        .bit_in (bus.serial_in),
        .word_o (sh_word),
        .last_o (sh_last),
        .full_o (sh_full)
    );

    always_comb begin
        state_d   = state_q;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        deliver   = 1'b0;
        word_perr = 1'b0;
        if (bus.enable) begin
            if (bus.sync) begin
                sh_load = 1'b1;
                state_d = RX_SHIFT;
            end else begin
                case (state_q)
                    RX_SHIFT: begin
                        sh_shift = !sh_full;
                        if (sh_last) begin
`ifdef SHIFTREG_RX_PARITY_EN
                            state_d = RX_PARITY;
`else
                            deliver = 1'b1;
                            state_d = RX_IDLE;
`endif
                        end
                    end
`ifdef SHIFTREG_RX_PARITY_EN
                    RX_PARITY: begin
                        // Counter is full here, so sh_word is the held data word.
                        deliver   = 1'b1;
                        word_perr = (^sh_word) ^ bus.serial_in;
                        state_d   = RX_IDLE;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        overrun_d    = overrun_q;
        parity_err_d = parity_err_q;
        if (deliver && (!data_valid_q || bus.data_ready)) begin
            data_out_d   = sh_word;
            parity_err_d = word_perr;
            data_valid_d = 1'b1;
        end else begin
            if (deliver) begin
                overrun_d = 1'b1;
            end
            if (bus.data_ready) begin
                data_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RX_IDLE;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overrun_q    <= overrun_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.overrun    = overrun_q;
    assign bus.parity_err = parity_err_q;

endmodule

// File: doc/shiftreg_rx.md
# shiftreg_rx

Serial-in, parallel-out receiver: the receiving end of the team's MSB-first parallel-load shift register link. It collects `WIDTH` serial bits per frame, MSB first, starting at a `sync` marker. It presents each completed word on a registered parallel output with a valid/ready handshake and a sticky overrun flag. It sits between the serial line and the consuming logic in the same clock domain.

## Interface
- `WIDTH`, default 4: data bits per frame (≥ 2).
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `enable`  in  1: bit strobe; serial input is sampled only on edges where `enable`=1.
- `sync`  in  1: frame start; the bit sampled with `sync`=1 is the MSB.
- `serial_in`  in  1: serial data, MSB first.
- `data_out`  out  WIDTH: last completed word.
- `data_valid`  out  1: `data_out` holds an unconsumed word.
- `data_ready`  in  1: consumer accepts the word when `data_valid`=1.
- `overrun`  out  1: sticky; a completed word was dropped.
- `parity_err`  out  1: parity result for the word in `data_out`.

## Operation
- FSM states: IDLE, SHIFT, and PARITY (PARITY only when parity is compiled in).
- IDLE: waits for `enable`=1 and `sync`=1. On that edge it loads the shift register with `serial_in` as the MSB, sets bit count to 1, and moves to SHIFT.
- SHIFT:
  - On each `enable`=1 edge: shift `{shreg[WIDTH-2:0], serial_in}` and increment the count.
  - When the count reaches `WIDTH`: the word is complete. Go to PARITY if enabled, otherwise deliver it and go to IDLE.
- `sync`=1 with `enable`=1 while in SHIFT or PARITY discards the partial frame. That bit becomes the MSB of a new frame (count = 1, state SHIFT).
- `enable`=0: shift register, count and state all hold. `sync` and `serial_in` are ignored.
- Delivery:
  - If `data_valid`=0, or `data_ready`=1 in the same cycle: load `data_out` and `parity_err`, and set `data_valid`=1.
  - Otherwise: drop the new word, keep the old word, and set `overrun`=1.
- Handshake: `data_valid` clears on an edge with `data_ready`=1 unless a new word is delivered on that same edge. `data_out` is stable while `data_valid`=1.
- `overrun` clears only on reset.
- Reset mid-frame: the partial frame is lost and the FSM returns to IDLE.

## Timing
- Reset values:
  - `data_out` = 0, `data_valid` = 0, `overrun` = 0, `parity_err` = 0.
  - FSM in IDLE, count = 0.
- Latency: `data_valid` rises on the same clock edge that samples the final bit of the frame (the LSB, or the parity bit). It is visible in the cycle after that edge.
- Back-to-back frames are supported. A `sync` may arrive on the enabled edge immediately after the final bit.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Bit count width: `$clog2(WIDTH+1)`. The count never wraps; it is reset to 1 on every `sync`.

## Configuration
- `SHIFTREG_RX_PARITY_EN` defined:
  - One extra enabled bit follows the LSB and is taken as an even-parity bit.
  - `parity_err` = XOR of the `WIDTH` data bits and the parity bit.
  - The word is delivered on the parity-bit edge.
- `SHIFTREG_RX_PARITY_EN` undefined:
  - No PARITY state; the word is delivered on the LSB edge.
  - `parity_err` is tied to 0. The port list is identical in both builds.

## Structure
- Shared package `shiftreg_pkg`: FSM state typedef (`RX_IDLE`, `RX_SHIFT`, `RX_PARITY`) and the default width constant `SHIFTREG_WIDTH` = 4, shared with the transmitter.
- One sub-module, `shiftreg_rx_shifter`: shift register plus bit counter, with load/shift/hold controls and a "full" flag.
- The top level contains the FSM, delivery/handshake logic and overrun logic.

## Test plan
All scenarios use `WIDTH` = 4.
1. Assert `reset` mid-frame → all outputs 0 immediately (asynchronous). Next frame with sync, bits 1,1,0,0 → `data_out`=4'b1100.
2. Sync with bits 1,0,1,1 on consecutive enabled cycles, `data_ready`=1 → `data_out`=4'b1011. `data_valid` high for exactly 1 cycle after the LSB edge.
3. Same frame with `enable`=0 for 2 cycles after bit 2 (`serial_in` toggling) → `data_out`=4'b1011 and delivery delayed by 2 cycles.
4. Frames 4'hA then 4'h5 with `data_ready`=0 → `data_out` stays 4'hA, `data_valid`=1, `overrun`=1. Then `data_ready`=1 for one cycle → `data_valid`=0 and `overrun` stays 1.
5. Sync, bits 1,1, then sync with 0,0,1,1 → `data_out`=4'b0011; the partial frame is discarded and `overrun` stays 0.
6. With `SHIFTREG_RX_PARITY_EN`:
   - bits 1,0,1,1 + parity 1 → `parity_err`=0.
   - same bits + parity 0 → `parity_err`=1.
   - In both cases `data_valid` rises on the parity edge.
